// File: rtl/sequence_recorder_if.sv
// Bus between the debounced button side / playback reader and sequence_recorder.
interface sequence_recorder_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] tamanho;
    logic [3:0]        botoes;
    logic [ADDR_W-1:0] rd_endereco;
    logic [3:0]        rd_dado;
    logic              mem_we;
    logic              gravando;
    logic              pronto;
    logic              invalido;
    logic              timeout;
    logic [ADDR_W:0]   contagem;
    logic [3:0]        db_estado;

    modport master (
        output iniciar, tamanho, botoes, rd_endereco,
        input  rd_dado, mem_we, gravando, pronto, invalido, timeout, contagem, db_estado
    );

    modport slave (
        input  iniciar, tamanho, botoes, rd_endereco,
        output rd_dado, mem_we, gravando, pronto, invalido, timeout, contagem, db_estado
    );
endinterface

// File: rtl/sequence_recorder.sv
// sequence_recorder: records tamanho+1 one-hot key presses into a 2**ADDR_W x 4 memory.
// Optional press timeout is built when SEQUENCE_RECORDER_TIMEOUT_EN is defined.
module sequence_recorder #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic               clock,
    input  logic               reset,
    sequence_recorder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        S_INICIAL       = 4'h0,
        S_PREPARACAO    = 4'h1,
        S_ESPERA_SOLTA  = 4'h2,
        S_ESPERA_JOGADA = 4'h3,
        S_REGISTRA      = 4'h4,
        S_COMPARA       = 4'h5,
        S_PROXIMO       = 4'h6,
        S_TIMEOUT       = 4'hD,
        S_FIM           = 4'hF
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] tam_q, tam_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        jogada_q, jogada_d;
    logic              pronto_q, pronto_d;
    logic              invalido_q, invalido_d;
    logic              mem_we_q, mem_we_d;
    logic              gravando_q, gravando_d;
    logic [3:0]        mem [DEPTH];

`ifdef SEQUENCE_RECORDER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            to_expired_c;

    assign to_expired_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout  = timeout_q;

    // Idle counter: zero outside espera_jogada, so it restarts on every entry
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_ESPERA_JOGADA) begin
            to_cnt_d = TO_W'(to_cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign bus.timeout = 1'b0;
`endif

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tam_d      = tam_q;
        cnt_d      = cnt_q;
        jogada_d   = jogada_q;
        pronto_d   = pronto_q;
        invalido_d = invalido_q;
        mem_we_d   = 1'b0;
`ifdef SEQUENCE_RECORDER_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_INICIAL: begin
                if (bus.iniciar) state_d = S_PREPARACAO;
            end
            S_PREPARACAO: begin
                addr_d     = '0;
                cnt_d      = '0;
                pronto_d   = 1'b0;
                invalido_d = 1'b0;
                tam_d      = bus.tamanho;
`ifdef SEQUENCE_RECORDER_TIMEOUT_EN
                timeout_d  = 1'b0;
`endif
                state_d    = S_ESPERA_SOLTA;
            end
            S_ESPERA_SOLTA: begin
                if (bus.botoes == 4'd0) state_d = S_ESPERA_JOGADA;
            end
            S_ESPERA_JOGADA: begin
                // A press on the expiry cycle still wins over the timeout
                if (bus.botoes != 4'd0) begin
                    jogada_d = bus.botoes;
                    mem_we_d = is_onehot(bus.botoes);
                    state_d  = S_REGISTRA;
                end
`ifdef SEQUENCE_RECORDER_TIMEOUT_EN
                else if (to_expired_c) begin
                    timeout_d = 1'b1;
                    state_d   = S_TIMEOUT;
                end
`endif
            end
            S_REGISTRA: begin
                if (is_onehot(jogada_q)) begin
                    cnt_d   = CNT_W'(cnt_q + 1'b1);
                    state_d = S_COMPARA;
                end else begin
                    invalido_d = 1'b1;
                    state_d    = S_INICIAL;
                end
            end
            S_COMPARA: begin
                state_d = (addr_q == tam_q) ? S_FIM : S_PROXIMO;
            end
            S_PROXIMO: begin
                addr_d  = ADDR_W'(addr_q + 1'b1);
                state_d = S_ESPERA_SOLTA;
            end
            S_FIM: begin
                pronto_d = 1'b1;
                state_d  = S_INICIAL;
            end
            default: state_d = S_INICIAL;
        endcase

        gravando_d = (state_d == S_PREPARACAO)    || (state_d == S_ESPERA_SOLTA) ||
                     (state_d == S_ESPERA_JOGADA) || (state_d == S_REGISTRA)     ||
                     (state_d == S_COMPARA)       || (state_d == S_PROXIMO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_INICIAL;
            addr_q     <= '0;
            tam_q      <= '0;
            cnt_q      <= '0;
            jogada_q   <= '0;
            pronto_q   <= 1'b0;
            invalido_q <= 1'b0;
            mem_we_q   <= 1'b0;
            gravando_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tam_q      <= tam_d;
            cnt_q      <= cnt_d;
            jogada_q   <= jogada_d;
            pronto_q   <= pronto_d;
            invalido_q <= invalido_d;
            mem_we_q   <= mem_we_d;
            gravando_q <= gravando_d;
        end
    end

    // Memory is not reset; a reset landing on the write cycle suppresses the write
    always_ff @(posedge clock) begin
        if (!reset && mem_we_q) begin
            mem[addr_q] <= jogada_q;
        end
    end

    assign bus.rd_dado  = mem[bus.rd_endereco];
    assign bus.mem_we   = mem_we_q;
    assign bus.gravando = gravando_q;
    assign bus.pronto   = pronto_q;
    assign bus.invalido = invalido_q;
    assign bus.contagem = cnt_q;

    // Unknown state codes read back as E
    always_comb begin
        bus.db_estado = 4'hE;
        case (state_q)
            S_INICIAL, S_PREPARACAO, S_ESPERA_SOLTA, S_ESPERA_JOGADA, S_REGISTRA,
            S_COMPARA, S_PROXIMO, S_TIMEOUT, S_FIM: bus.db_estado = 4'(state_q);
            default: bus.db_estado = 4'hE;
        endcase
    end
endmodule

// File: tb/tb_sequence_recorder.sv
// Bench for sequence_recorder: sequential behavioural model, per-cycle compare, directed + random runs.
module tb_sequence_recorder;
    localparam int unsigned AW = 4;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sequence_recorder_if #(.ADDR_W(AW)) bus ();

    sequence_recorder #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model state: what each output must be during the current cycle
    logic [3:0] m_mem [16];
    bit         m_val [16];
    int  m_db = 0, m_cnt = 0, m_addr = 0, m_tam = 0;
    bit  m_we = 0, m_pronto = 0, m_inv = 0, m_to = 0;
    bit  rs = 0;
    bit  chk_en = 0;
    bit  rnd_rd = 0;
    int  we_pulses = 0;

    task automatic tick();
        @(posedge clock);
        rs = reset;
    endtask

    // One recording session described as a sequence of waits; returns on reset or when back in inicial
    task automatic model_run();
        logic [3:0] jog;
        int k;
        m_db = 0;
        m_we = 0;
        do begin
            tick(); if (rs) return;
        end while (!bus.iniciar);
        m_db = 1;
        tick(); if (rs) return;
        m_addr = 0; m_cnt = 0; m_pronto = 0; m_inv = 0; m_to = 0;
        m_tam = int'(bus.tamanho);
        forever begin
            m_db = 2;
            do begin
                tick(); if (rs) return;
            end while (bus.botoes != 4'd0);
            m_db = 3;
            k = 0;
            jog = 4'd0;
            forever begin
                tick(); if (rs) return;
                if (bus.botoes != 4'd0) begin
                    jog = bus.botoes;
                    break;
                end
`ifdef SEQUENCE_RECORDER_TIMEOUT_EN
                if (k == TO - 1) begin
                    m_db = 13;
                    m_to = 1;
                    tick();
                    return;
                end
`endif
                k++;
            end
            m_db = 4;
            m_we = ($countones(jog) == 1);
            tick(); if (rs) return;
            m_we = 0;
            if ($countones(jog) != 1) begin
                m_inv = 1;
                return;
            end
            m_mem[m_addr] = jog;
            m_val[m_addr] = 1;
            m_cnt++;
            m_db = 5;
            tick(); if (rs) return;
            if (m_addr == m_tam) begin
                m_db = 15;
                tick(); if (rs) return;
                m_pronto = 1;
                return;
            end
            m_db = 6;
            tick(); if (rs) return;
            m_addr++;
        end
    endtask

    initial begin
        forever begin
            model_run();
            if (rs) begin
                m_db = 0; m_we = 0; m_pronto = 0; m_inv = 0; m_to = 0; m_cnt = 0; m_addr = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("db_estado", int'(bus.db_estado), m_db);
            chk("gravando",  int'(bus.gravando), int'(m_db >= 1 && m_db <= 6));
            chk("mem_we",    int'(bus.mem_we), int'(m_we));
            chk("pronto",    int'(bus.pronto), int'(m_pronto));
            chk("invalido",  int'(bus.invalido), int'(m_inv));
            chk("timeout",   int'(bus.timeout), int'(m_to));
            chk("contagem",  int'(bus.contagem), m_cnt);
            if (m_val[bus.rd_endereco]) chk("rd_dado", int'(bus.rd_dado), int'(m_mem[bus.rd_endereco]));
            if (bus.mem_we) we_pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (rnd_rd) bus.rd_endereco = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic wait_model(input int s, input int budget);
        int n;
        n = 0;
        while (m_db != s && n < budget) begin
            step(1);
            n++;
        end
        if (m_db != s) begin
            tests++;
            fails++;
            $display("FAIL wait_state_%0d: still in %0d after %0d cycles", s, m_db, budget);
        end
    endtask

    task automatic press(input logic [3:0] key, input int hold, input int rel);
        wait_model(3, 60);
        bus.botoes = key;
        step(hold);
        bus.botoes = 4'd0;
        step(rel);
    endtask

    task automatic start(input logic [3:0] tam);
        bus.tamanho = tam;
        bus.iniciar = 1'b1;
        step(1);
        bus.iniciar = 1'b0;
    endtask

    task automatic rd_check(input int addr, input int exp);
        bus.rd_endereco = 4'(addr);
        #1;
        chk($sformatf("lit_rd_dado[%0d]", addr), int'(bus.rd_dado), exp);
    endtask

    task automatic finish_run();
        int guard;
        guard = 0;
        bus.iniciar = 1'b0;
        while (m_db != 0 && guard < 100) begin
            bus.botoes = 4'b0001 << $urandom_range(0, 3);
            step(2);
            bus.botoes = 4'd0;
            step(3);
            guard++;
        end
        tests++;
        if (m_db != 0) begin
            fails++;
            $display("FAIL finish_run: model state %0d after %0d presses", m_db, guard);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bus.iniciar = 1'b0;
        bus.tamanho = '0;
        bus.botoes = 4'd0;
        bus.rd_endereco = '0;
        step(3);
        reset = 1'b0;
        chk_en = 1;

        // Reset then idle
        step(10);
        chk("lit_idle_db", int'(bus.db_estado), 0);
        chk("lit_idle_pronto", int'(bus.pronto), 0);
        chk("lit_idle_contagem", int'(bus.contagem), 0);

        // Normal run of four presses
        w0 = we_pulses;
        start(4'd3);
        press(4'b0001, 3, 2);
        press(4'b0100, 3, 2);
        press(4'b1000, 3, 2);
        press(4'b0010, 3, 2);
        wait_model(0, 30);
        step(1);
        chk("lit_run_pronto", int'(bus.pronto), 1);
        chk("lit_run_contagem", int'(bus.contagem), 4);
        chk("lit_run_we_pulses", we_pulses - w0, 4);
        rd_check(0, 1);
        rd_check(1, 4);
        rd_check(2, 8);
        rd_check(3, 2);

        // Held key records once
        w0 = we_pulses;
        start(4'd1);
        wait_model(3, 30);
        bus.botoes = 4'b0010;
        step(12);
        chk("lit_held_db", int'(bus.db_estado), 2);
        step(8);
        bus.botoes = 4'd0;
        step(2);
        press(4'b0001, 2, 2);
        wait_model(0, 30);
        chk("lit_held_pronto", int'(bus.pronto), 1);
        chk("lit_held_we_pulses", we_pulses - w0, 2);
        rd_check(0, 2);
        rd_check(1, 1);

        // Invalid second press
        start(4'd3);
        press(4'b0100, 2, 2);
        press(4'b0011, 2, 2);
        wait_model(0, 30);
        chk("lit_inv_invalido", int'(bus.invalido), 1);
        chk("lit_inv_pronto", int'(bus.pronto), 0);
        chk("lit_inv_contagem", int'(bus.contagem), 1);
        rd_check(0, 4);
        rd_check(1, 1);

        // Reset in the middle of a run keeps memory
        start(4'd5);
        press(4'b1000, 2, 2);
        press(4'b0001, 2, 2);
        wait_model(3, 30);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("lit_rst_db", int'(bus.db_estado), 0);
        chk("lit_rst_contagem", int'(bus.contagem), 0);
        chk("lit_rst_gravando", int'(bus.gravando), 0);
        rd_check(0, 8);
        rd_check(1, 1);
        start(4'd0);
        press(4'b0100, 2, 2);
        wait_model(0, 30);
        chk("lit_fresh_pronto", int'(bus.pronto), 1);
        rd_check(0, 4);

`ifdef SEQUENCE_RECORDER_TIMEOUT_EN
        // Expiry after TO idle cycles, then a press on the last allowed cycle
        start(4'd2);
        wait_model(3, 30);
        step(TO);
        chk("lit_to_db", int'(bus.db_estado), 13);
        chk("lit_to_flag", int'(bus.timeout), 1);
        step(1);
        chk("lit_to_db_after", int'(bus.db_estado), 0);
        start(4'd0);
        wait_model(3, 30);
        step(TO - 1);
        bus.botoes = 4'b1000;
        step(1);
        bus.botoes = 4'd0;
        chk("lit_to_press_db", int'(bus.db_estado), 4);
        wait_model(0, 30);
        chk("lit_to_press_flag", int'(bus.timeout), 0);
        chk("lit_to_press_pronto", int'(bus.pronto), 1);
`endif

        // Randomized sessions
        rnd_rd = 1;
        for (int r = 0; r < 40; r++) begin
            int tam;
            tam = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 4));
            bus.tamanho = 4'(tam);
            bus.iniciar = 1'b1;
            step($urandom_range(1, 3));
            bus.iniciar = 1'b0;
            bus.tamanho = 4'($urandom_range(0, 15));
            for (int p = 0; p <= tam; p++) begin
                bus.botoes = ($urandom_range(0, 12) == 0) ? 4'($urandom_range(1, 15))
                                                          : (4'b0001 << $urandom_range(0, 3));
                step($urandom_range(1, 4));
                bus.botoes = 4'd0;
                bus.iniciar = ($urandom_range(0, 9) == 0);
                step($urandom_range(1, 3));
                bus.iniciar = 1'b0;
                if ($urandom_range(0, 99) == 0) begin
                    reset = 1'b1;
                    step(1);
                    reset = 1'b0;
                end
            end
            finish_run();
        end

        step(2);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sequence_recorder.md
Name: sequence_recorder

Overview:
- Control unit plus small datapath that records a sequence of button presses into an internal 16x4 memory.
- It is the writer counterpart of the compare/playback control unit, which reads the memory and checks it against the player's presses.
- Records tamanho+1 one-hot key codes, with release-before-press handshaking, and reports completion or error through sticky status flags.
- Sits between the debounced button inputs and the shared sequence memory; a read port lets the playback side or a bench inspect the stored contents.

Parameters:
- ADDR_W, 4, memory address width; depth = 2**ADDR_W entries.
- TIMEOUT_CYCLES, 5000, idle cycles allowed in espera_jogada; used only when the timeout macro is defined.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; sampled on rising clock edge
iniciar  in  1  start recording; honoured only in state inicial
tamanho  in  ADDR_W  last index to record (records tamanho+1 entries); latched in preparacao
botoes  in  4  button levels, already synchronised and debounced
rd_endereco  in  ADDR_W  read address
rd_dado  out  4  mem[rd_endereco], combinational read
mem_we  out  1  high during the cycle a word is written
gravando  out  1  high while recording is in progress
pronto  out  1  sticky: sequence fully recorded
invalido  out  1  sticky: more than one key pressed at once
timeout  out  1  sticky: no press within TIMEOUT_CYCLES (0 when macro absent)
contagem  out  ADDR_W+1  number of entries written in the current run
db_estado  out  4  current state code, for display

Behaviour:
- Reset (synchronous): state inicial; pronto, invalido, timeout, mem_we, gravando = 0; contagem = 0; address counter = 0.
- Reset does not clear memory contents. Reset in the middle of a run returns to inicial on the next edge; entries already written are kept.
- States (db_estado code):
  - inicial (0): wait; iniciar=1 -> preparacao. Sticky flags hold.
  - preparacao (1): clear address, contagem, pronto, invalido and timeout; latch tamanho -> espera_solta.
  - espera_solta (2): stay until botoes==0 -> espera_jogada.
  - espera_jogada (3): on botoes!=0, capture botoes into jogada reg on the same edge -> registra.
  - registra (4): if jogada is one-hot, mem_we=1, write mem[addr]<=jogada, contagem+1 -> compara. Otherwise no write; set invalido -> inicial.
  - compara (5): addr==tamanho_latched -> fim; else -> proximo.
  - proximo (6): addr+1 -> espera_solta.
  - fim (F): set pronto -> inicial.
  - Any other code: db_estado=E, next state inicial.
- gravando = 1 in states 1-6.
- Latency: first cycle with botoes!=0 in espera_jogada = cycle N. mem_we is high in cycle N+1; the write is committed at the end of N+1, and rd_dado reflects it from N+2.
- A held key never records twice, because a release is required before each press.
- Address never wraps: tamanho = 2**ADDR_W-1 ends exactly at the last entry.
- iniciar asserted while not in inicial is ignored.

Optional Feature:
- Macro SEQUENCE_RECORDER_TIMEOUT_EN.
- Defined: a cycle counter is zeroed on entry to espera_jogada and increments each cycle spent there. When it reaches TIMEOUT_CYCLES-1 with botoes still 0, set timeout and go to inicial via state timeout_st (db_estado=D, 1 cycle). If the press and the expiry fall on the same cycle, the press wins.
- Not defined: no counter logic; timeout is tied to 0; espera_jogada waits indefinitely.

Test Plan:
- Reset then idle: after reset, 10 cycles with iniciar=0 -> db_estado=0, all flags 0, contagem=0.
- Normal run: tamanho=3, presses 0001, 0100, 1000, 0010, each separated by a release -> pronto=1, contagem=4, rd_dado at addresses 0..3 = 1,4,8,2; mem_we pulses exactly 4 times.
- Held key: press 0010 held 20 cycles with tamanho=1 -> single write; state stays 2 until release; second press 0001 -> mem[1]=1, pronto=1.
- Invalid press: second press 0011 -> invalido=1, pronto=0, contagem=1, state returns to 0; mem[1] unchanged.
- Mid-run reset: reset asserted in state 3 after 2 writes -> next edge db_estado=0, flags 0; mem[0..1] keep their values; a fresh run then works.
- Timeout (macro on, TIMEOUT_CYCLES=8): no press after entering state 3 -> timeout=1 after 8 cycles in state 3, db_estado D for 1 cycle then 0. A press on cycle 8 -> recorded, timeout=0.
